datapath_xyz: RTL and testbench

//  Register/ALU datapath driven by the control unit's per-cycle codes Tx/Ty/Tz/Tula.

---
 rtl/datapath_xyz_pkg.sv | 24 ++
 rtl/datapath_xyz_ula.sv | 41 ++++
 rtl/datapath_xyz.sv | 78 +++++++
 tb/tb_datapath_xyz.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/datapath_xyz_pkg.sv
// Shared operation codes for the control unit and the X/Y/Z datapath.
// Register op codes and ULA op codes live here, so no literal codes appear in the RTL.
package datapath_xyz_pkg;

    localparam logic [2:0] REG_HOLD   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_SHIFTR = 3'd2;
    localparam logic [2:0] REG_SHIFTL = 3'd3;
    localparam logic [2:0] REG_RESET  = 3'd4;

    localparam logic [2:0] ULA_ADD   = 3'd0;
    localparam logic [2:0] ULA_SUB   = 3'd1;
    localparam logic [2:0] ULA_MAIOR = 3'd2;
    localparam logic [2:0] ULA_MENOR = 3'd3;
    localparam logic [2:0] ULA_IGUAL = 3'd4;
    localparam logic [2:0] ULA_XOR   = 3'd5;
    localparam logic [2:0] ULA_AND   = 3'd6;

    // Codes above RESET are not register operations.
    function automatic logic reg_op_illegal(input logic [2:0] op);
        return op > REG_RESET;
    endfunction

endpackage

// File: rtl/datapath_xyz_ula.sv
// Combinational ULA: a op b -> res, carry/borrow out, illegal-code flag.
module ula
    import datapath_xyz_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] res,
    output logic         cout,
    output logic         illegal
);

    logic [W:0] wide;

    always_comb begin
        wide    = '0;
        res     = '0;
        cout    = 1'b0;
        illegal = 1'b0;
        case (op)
            ULA_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[W-1:0];
                cout = wide[W];
            end
            ULA_SUB: begin
                res  = a - b;
                cout = (a < b);
            end
            ULA_MAIOR: res = {{(W-1){1'b0}}, (a > b)};
            ULA_MENOR: res = {{(W-1){1'b0}}, (a < b)};
            ULA_IGUAL: res = {{(W-1){1'b0}}, (a == b)};
            ULA_XOR:   res = a ^ b;
            ULA_AND:   res = a & b;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_xyz.sv
// X/Y/Z register datapath: data_in -> X, ULA(X,Y) -> Y, Y -> Z, with carry/zero
// flags and a sticky error flag for illegal register or ULA codes.
module datapath_xyz
    import datapath_xyz_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [2:0]   Tx,
    input  logic [2:0]   Ty,
    input  logic [2:0]   Tz,
    input  logic [2:0]   Tula,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic [W-1:0] z_out,
    output logic         carry,
    output logic         zero,
    output logic         op_error
);

    logic [W-1:0] ula_res;
    logic         ula_cout;
    logic         ula_illegal;
    logic         y_load;
    logic         err_now;

    ula #(.W(W)) u_ula (
        .a       (x_out),
        .b       (y_out),
        .op      (Tula),
        .res     (ula_res),
        .cout    (ula_cout),
        .illegal (ula_illegal)
    );

    // Illegal register codes fall into the default arm and hold the register.
    function automatic logic [W-1:0] reg_next(input logic [W-1:0] cur,
                                              input logic [2:0]   op,
                                              input logic [W-1:0] src);
        case (op)
            REG_LOAD:   return src;
            REG_SHIFTR: return {1'b0, cur[W-1:1]};
            REG_SHIFTL: return {cur[W-2:0], 1'b0};
            REG_RESET:  return '0;
            default:    return cur;
        endcase
    endfunction

    assign y_load  = (Ty == REG_LOAD);
    // Tula only matters when Y actually consumes the ULA result.
    assign err_now = reg_op_illegal(Tx) | reg_op_illegal(Ty) | reg_op_illegal(Tz)
                   | (y_load & ula_illegal);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_out    <= '0;
            y_out    <= '0;
            z_out    <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            op_error <= 1'b0;
        end else begin
            x_out <= reg_next(x_out, Tx, data_in);
            z_out <= reg_next(z_out, Tz, y_out);
            if (y_load) begin
                y_out <= ula_res;
                carry <= ula_cout;
                zero  <= (ula_res == '0);
            end else begin
                y_out <= reg_next(y_out, Ty, '0);
            end
            op_error <= op_error | err_now;
        end
    end

endmodule

// File: tb/tb_datapath_xyz.sv
// Directed and randomized checks of datapath_xyz (W=4) against an arithmetic reference model.
module tb_datapath_xyz;

    localparam int W = 4;
    localparam int M = 16;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   Tx = '0, Ty = '0, Tz = '0, Tula = '0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] x_out, y_out, z_out;
    logic         carry, zero, op_error;

    int tests = 0;
    int fails = 0;

    int mx = 0, my = 0, mz = 0, mc = 0, mzr = 0, merr = 0;

    datapath_xyz #(.W(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .Tx       (Tx),
        .Ty       (Ty),
        .Tz       (Tz),
        .Tula     (Tula),
        .data_in  (data_in),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .carry    (carry),
        .zero     (zero),
        .op_error (op_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int reg_model(input int v, input int op, input int src);
        case (op)
            1:       return src;
            2:       return v / 2;
            3:       return (v * 2) % M;
            4:       return 0;
            default: return v;
        endcase
    endfunction

    task automatic cyc(input logic rn, input int tx, input int ty, input int tz,
                       input int tula, input int din, input string tag);
        int nx, ny, nz, nc, nzr, nerr, s;
        @(negedge clock);
        reset_n = rn;
        Tx = 3'(tx); Ty = 3'(ty); Tz = 3'(tz); Tula = 3'(tula); data_in = W'(din);
        nc = mc; nzr = mzr; nerr = merr;
        if (!rn) begin
            nx = 0; ny = 0; nz = 0; nc = 0; nzr = 0; nerr = 0;
        end else begin
            nx = reg_model(mx, tx, din);
            nz = reg_model(mz, tz, my);
            if (ty == 1) begin
                nc = 0;
                case (tula)
                    0: begin s = mx + my; ny = s % M; nc = (s >= M) ? 1 : 0; end
                    1: begin ny = (mx + M - my) % M; nc = (mx < my) ? 1 : 0; end
                    2: ny = (mx > my) ? 1 : 0;
                    3: ny = (mx < my) ? 1 : 0;
                    4: ny = (mx == my) ? 1 : 0;
                    5: ny = mx ^ my;
                    6: ny = mx & my;
                    default: begin ny = 0; nerr = 1; end
                endcase
                nzr = (ny == 0) ? 1 : 0;
            end else begin
                ny = reg_model(my, ty, 0);
            end
            if (tx > 4 || ty > 4 || tz > 4) nerr = 1;
        end
        @(posedge clock);
        #1;
        mx = nx; my = ny; mz = nz; mc = nc; mzr = nzr; merr = nerr;
        chk({tag, ".x"}, int'(x_out), mx);
        chk({tag, ".y"}, int'(y_out), my);
        chk({tag, ".z"}, int'(z_out), mz);
        chk({tag, ".carry"}, int'(carry), mc);
        chk({tag, ".zero"}, int'(zero), mzr);
        chk({tag, ".err"}, int'(op_error), merr);
    endtask

    // Leaves X=xv, Y=yv (Y loaded as 0+yv through the ULA).
    task automatic set_xy(input int xv, input int yv);
        cyc(1, 1, 4, 0, 0, yv, "setxy_a");
        cyc(1, 1, 1, 0, 0, xv, "setxy_b");
    endtask

    initial begin
        // Reset with a pending load
        cyc(0, 1, 0, 0, 0, 5, "rst");
        chk("rst_x_const", int'(x_out), 0);

        // Control-unit sequence
        cyc(1, 1, 4, 4, 0, 3, "seq1");
        chk("seq1_x", int'(x_out), 3);
        cyc(1, 1, 1, 0, 0, 5, "seq2");
        chk("seq2_y", int'(y_out), 3);
        cyc(1, 4, 1, 0, 0, 0, "seq3");
        chk("seq3_y", int'(y_out), 8);
        cyc(1, 0, 2, 0, 0, 0, "seq4");
        chk("seq4_y", int'(y_out), 4);
        cyc(1, 0, 4, 1, 0, 0, "seq5");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, $urandom_range(0, 15), "hold");
        chk("seq_z_const", int'(z_out), 4);

        // Reset mid-sequence
        cyc(0, 1, 1, 1, 0, 9, "rst_mid");
        chk("rst_mid_z", int'(z_out), 0);

        // Arithmetic
        set_xy(9, 8);
        cyc(1, 0, 1, 0, 0, 0, "add_ovf");
        chk("add_y", int'(y_out), 1);
        chk("add_c", int'(carry), 1);
        set_xy(3, 5);
        cyc(1, 0, 1, 0, 1, 0, "sub_brw");
        chk("sub_y", int'(y_out), 14);
        chk("sub_c", int'(carry), 1);
        chk("sub_z", int'(zero), 0);

        // Compare / logic
        set_xy(6, 2);
        cyc(1, 0, 1, 0, 2, 0, "maior");
        chk("maior_y", int'(y_out), 1);
        cyc(1, 0, 1, 0, 3, 0, "menor");
        chk("menor_zero", int'(zero), 1);
        set_xy(12, 10);
        cyc(1, 0, 1, 0, 5, 0, "xor");
        chk("xor_y", int'(y_out), 6);
        set_xy(12, 10);
        cyc(1, 0, 1, 0, 6, 0, "and");
        chk("and_y", int'(y_out), 8);
        set_xy(7, 7);
        cyc(1, 0, 1, 0, 4, 0, "igual");

        // Shifts
        cyc(1, 1, 0, 0, 0, 9, "sh_ld");
        cyc(1, 3, 0, 0, 0, 0, "shl");
        chk("shl_x", int'(x_out), 2);
        cyc(1, 2, 0, 0, 0, 0, "shr1");
        cyc(1, 2, 0, 0, 0, 0, "shr2");
        chk("shr2_x", int'(x_out), 0);

        // Errors
        cyc(1, 1, 0, 0, 0, 5, "err_ld");
        cyc(1, 7, 0, 0, 0, 2, "err_tx7");
        chk("err_x_hold", int'(x_out), 5);
        chk("err_set", int'(op_error), 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, $urandom_range(0, 7), 0, "err_sticky");
        cyc(1, 0, 1, 0, 7, 0, "ula7");
        chk("ula7_zero", int'(zero), 1);
        cyc(0, 0, 0, 0, 0, 0, "err_rst");
        cyc(1, 0, 0, 0, 7, 0, "ula7_noload");
        chk("ula7_noload_err", int'(op_error), 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 24) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15), "rand");
            if ($urandom_range(0, 9) == 0) cyc(0, 0, 0, 0, 0, 0, "rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
